// File: rtl/acumulador_suma.sv
// acumulador_suma
// Streaming accumulator: sums blocks of up to K unsigned N-bit operands into a
// W = N + clog2(K) bit total, so a full block of all-ones operands cannot wrap.
// Each completed total is held on a registered output until downstream takes it.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   operand present on dato
//   in_ready   block can accept an operand this cycle
//   dato       N-bit unsigned operand
//   in_last    closes the block early when sampled with an accepted operand
//   out_valid  resultado/n_datos hold a completed block
//   out_ready  downstream consumes the result this cycle
//   resultado  W-bit sum of the block
//   n_datos    operands in the block (1..K)
//
// state  | meaning
// ACUM   | accepting operands, accumulating the open block
// SALIDA | result presented, waiting for out_ready; input stalled

module acumulador_suma #(
    parameter int N = 5,
    parameter int K = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N-1:0]               dato,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N+$clog2(K)-1:0]     resultado,
    output logic [$clog2(K+1)-1:0]     n_datos
);

    localparam int W  = N + $clog2(K);
    localparam int CW = $clog2(K + 1);
    localparam logic [CW-1:0] CNT_ULT = CW'(K - 1);

    typedef enum logic {
        ACUM   = 1'b0,
        SALIDA = 1'b1
    } estado_t;

    estado_t         estado;
    logic [W-1:0]    acc;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    suma;
    logic [CW-1:0]   cnt_inc;

    // Handshake flags come from the state register only, so there is no
    // combinational path from in_valid or out_ready.
    assign in_ready  = (estado == ACUM);
    assign out_valid = (estado == SALIDA);

    assign suma    = acc + {{(W-N){1'b0}}, dato};
    assign cnt_inc = cnt + CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            estado    <= ACUM;
            acc       <= '0;
            cnt       <= '0;
            resultado <= '0;
            n_datos   <= '0;
        end else begin
            case (estado)
                ACUM: begin
                    if (in_valid) begin
                        acc <= suma;
                        cnt <= cnt_inc;
                        // K-th beat closes the block exactly once, with or without in_last.
                        if (cnt == CNT_ULT || in_last) begin
                            resultado <= suma;
                            n_datos   <= cnt_inc;
                            estado    <= SALIDA;
                        end
                    end
                end
                SALIDA: begin
                    if (out_ready) begin
                        acc    <= '0;
                        cnt    <= '0;
                        estado <= ACUM;
                    end
                end
                default: estado <= ACUM;
            endcase
        end
    end

endmodule

// File: tb/tb_acumulador_suma.sv
module tb_acumulador_suma;

    localparam int N  = 5;
    localparam int K  = 4;
    localparam int W  = 7;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  dato;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  resultado;
    logic [CW-1:0] n_datos;

    int checks = 0;
    int errors = 0;

    acumulador_suma #(.N(N), .K(K)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dato      (dato),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .resultado (resultado),
        .n_datos   (n_datos)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of input, then sample 1 time unit after the edge.
    task automatic beat(input logic v, input logic [N-1:0] d, input logic l);
        in_valid = v;
        dato     = d;
        in_last  = l;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input int exp_res, input int exp_n);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_res"},   32'(resultado), 32'(exp_res));
        chk({tag, "_n"},     32'(n_datos),   32'(exp_n));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; dato = '0; in_last = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        beat(1'b0, 5'd0, 1'b0);
        chk("rst_ready", 32'(in_ready),  32'd1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_res",   32'(resultado), 32'd0);
        chk("rst_n",     32'(n_datos),   32'd0);

        // Basic block
        out_ready = 1'b1;
        beat(1'b1, 5'd3, 1'b0);
        beat(1'b1, 5'd7, 1'b0);
        beat(1'b1, 5'd10, 1'b0);
        chk("basic_open_valid", 32'(out_valid), 32'd0);
        beat(1'b1, 5'd31, 1'b0);
        chk_out("basic", 51, 4);
        beat(1'b0, 5'd0, 1'b0);
        chk("basic_back_ready", 32'(in_ready),  32'd1);
        chk("basic_back_valid", 32'(out_valid), 32'd0);

        // Max value, then cleared accumulator
        repeat (4) beat(1'b1, 5'd31, 1'b0);
        chk_out("max", 124, 4);
        beat(1'b0, 5'd0, 1'b0);
        repeat (4) beat(1'b1, 5'd1, 1'b0);
        chk_out("clear", 4, 4);
        beat(1'b0, 5'd0, 1'b0);

        // Early close
        beat(1'b1, 5'd5, 1'b0);
        beat(1'b1, 5'd6, 1'b1);
        chk_out("early2", 11, 2);
        beat(1'b0, 5'd0, 1'b0);
        beat(1'b1, 5'd9, 1'b1);
        chk_out("early1", 9, 1);
        beat(1'b0, 5'd0, 1'b1);
        chk("last_idle_valid", 32'(out_valid), 32'd0);

        // Backpressure
        out_ready = 1'b0;
        beat(1'b1, 5'd1, 1'b0);
        beat(1'b1, 5'd2, 1'b0);
        beat(1'b1, 5'd3, 1'b0);
        beat(1'b1, 5'd4, 1'b0);
        chk_out("bp_start", 10, 4);
        for (int i = 0; i < 5; i++) begin
            beat(1'b1, 5'd20, 1'b0);
            chk_out("bp_hold", 10, 4);
        end
        out_ready = 1'b1;
        beat(1'b1, 5'd20, 1'b0);
        chk("bp_cons_ready", 32'(in_ready),  32'd1);
        chk("bp_cons_valid", 32'(out_valid), 32'd0);
        beat(1'b1, 5'd20, 1'b0);
        beat(1'b1, 5'd1, 1'b0);
        beat(1'b1, 5'd2, 1'b0);
        chk("bp_next_open", 32'(out_valid), 32'd0);
        beat(1'b1, 5'd3, 1'b0);
        chk_out("bp_next", 26, 4);
        beat(1'b0, 5'd0, 1'b0);

        // Bubbles
        beat(1'b1, 5'd2, 1'b0);
        repeat (3) beat(1'b0, 5'd17, 1'b1);
        chk("bub_gap_valid", 32'(out_valid), 32'd0);
        beat(1'b1, 5'd2, 1'b0);
        beat(1'b0, 5'd9, 1'b0);
        beat(1'b1, 5'd2, 1'b0);
        beat(1'b1, 5'd2, 1'b0);
        chk_out("bubbles", 8, 4);
        beat(1'b0, 5'd0, 1'b0);

        // Reset mid-block
        beat(1'b1, 5'd8, 1'b0);
        beat(1'b1, 5'd8, 1'b0);
        rst = 1'b1;
        beat(1'b1, 5'd8, 1'b0);
        rst = 1'b0;
        repeat (4) beat(1'b1, 5'd1, 1'b0);
        chk_out("rst_mid", 4, 4);

        // Reset while a result is being consumed
        rst = 1'b1;
        beat(1'b0, 5'd0, 1'b0);
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_res",   32'(resultado), 32'd0);
        chk("rst_out_n",     32'(n_datos),   32'd0);
        chk("rst_out_ready", 32'(in_ready),  32'd1);
        beat(1'b1, 5'd2, 1'b0);
        beat(1'b1, 5'd3, 1'b1);
        chk_out("post_rst", 5, 2);
        beat(1'b0, 5'd0, 1'b0);

        // K-th beat together with in_last closes only once
        beat(1'b1, 5'd1, 1'b0);
        beat(1'b1, 5'd1, 1'b0);
        beat(1'b1, 5'd1, 1'b0);
        beat(1'b1, 5'd1, 1'b1);
        chk_out("klast", 4, 4);
        beat(1'b0, 5'd0, 1'b0);
        chk("klast_back", 32'(in_ready), 32'd1);
        beat(1'b1, 5'd7, 1'b1);
        chk_out("single7", 7, 1);
        beat(1'b0, 5'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
